// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the load/store unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The response cycle is the IDLE cycle with resp_valid high, so it has no own state.
  typedef enum logic [1:0] {StIdle, StRd, StRdData, StWr} lsu_state_t;

  function automatic logic [31:0] lsu_extract(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [1:0] size, input logic is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] lsu_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] offset, input logic [1:0] size);
    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] data;
    shift = {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00ff << shift;
        data = {24'b0, wdata[7:0]} << shift;
      end
      SZ_HALF: begin
        mask = 32'h0000_ffff << shift;
        data = {16'b0, wdata[15:0]} << shift;
      end
      default: begin
        mask = 32'hffff_ffff;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: load extraction/extension and sub-word store merge.
module lsu_byte_lane
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  assign load_data_o  = lsu_extract(rdata_i, offset_i, size_i, is_unsigned_i);
  assign merge_data_o = lsu_merge(rdata_i, wdata_i, offset_i, size_i);

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only, registered-read data memory.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  lsu_state_t state_q, state_d;

  logic        op_write_q;
  logic [1:0]  op_size_q;
  logic        op_unsigned_q;
  logic [1:0]  op_offset_q;
  logic [31:0] op_wdata_q;

  logic                  resp_valid_d;
  logic [31:0]           resp_rdata_d;
  logic                  resp_misaligned_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic [DATA_WIDTH-1:0] mem_in_d;
  logic                  mem_we_d;

  logic        accept;
  logic        misaligned;
  logic        word_store;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        unused_addr_hi;

  // Upper address bits wrap away by design.
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready  = (state_q == StIdle);
  assign accept     = req_ready && req_valid;
  assign word_store = req_write && (req_size == SZ_WORD);

  always_comb begin
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  lsu_byte_lane u_byte_lane (
    .rdata_i       (mem_out),
    .wdata_i       (op_wdata_q),
    .offset_i      (op_offset_q),
    .size_i        (op_size_q),
    .is_unsigned_i (op_unsigned_q),
    .load_data_o   (load_data),
    .merge_data_o  (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !misaligned) begin
          state_d = word_store ? StWr : StRd;
        end
      end
      StRd:     state_d = StRdData;
      StRdData: state_d = op_write_q ? StWr : StIdle;
      StWr:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; the response fields default to 0 so
  // they clear the cycle after a response.
  always_comb begin
    resp_valid_d      = 1'b0;
    resp_rdata_d      = '0;
    resp_misaligned_d = 1'b0;
    mem_address_d     = mem_address;
    mem_in_d          = mem_in;
    mem_we_d          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            resp_valid_d      = 1'b1;
            resp_misaligned_d = 1'b1;
          end else begin
            mem_address_d = req_addr[ADDR_WIDTH+1:2];
            if (word_store) begin
              mem_in_d = req_wdata;
              mem_we_d = 1'b1;
            end
          end
        end
      end
      StRdData: begin
        if (op_write_q) begin
          mem_in_d = merge_data;
          mem_we_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      StWr:    resp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_address     <= '0;
      mem_in          <= '0;
      mem_we          <= 1'b0;
    end else begin
      resp_valid      <= resp_valid_d;
      resp_rdata      <= resp_rdata_d;
      resp_misaligned <= resp_misaligned_d;
      mem_address     <= mem_address_d;
      mem_in          <= mem_in_d;
      mem_we          <= mem_we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write_q    <= 1'b0;
      op_size_q     <= SZ_BYTE;
      op_unsigned_q <= 1'b0;
      op_offset_q   <= 2'b00;
      op_wdata_q    <= '0;
    end else if (accept) begin
      op_write_q    <= req_write;
      op_size_q     <= req_size;
      op_unsigned_q <= req_unsigned;
      op_offset_q   <= req_addr[1:0];
      op_wdata_q    <= req_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural registered-read word memory.
module tb_load_store_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_in;
  logic          mem_we;
  logic [31:0]   mem_out;

  logic [31:0] mem [1024];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          we;
    int          acc_cyc;
    int          we_base;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int we_cnt   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_address     (mem_address),
    .mem_in          (mem_in),
    .mem_we          (mem_we),
    .mem_out         (mem_out)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_in;
    mem_out <= mem[mem_address];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: counts write pulses and pops the scoreboard on every response.
  initial begin
    exp_t  e;
    string nm;
    logic  prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
        end else begin
          e  = sb_q.pop_front();
          nm = name_q.pop_front();
          check({nm, " rdata"}, resp_rdata, e.rdata);
          check({nm, " misaligned"}, {31'b0, resp_misaligned}, {31'b0, e.mis});
          check({nm, " latency"}, cyc - e.acc_cyc + 1, e.lat);
          check({nm, " we_pulses"}, we_cnt - e.we_base, e.we);
        end
      end else if (prev_valid) begin
        check("resp_rdata_cleared", resp_rdata, 32'h0);
        check("resp_misaligned_cleared", {31'b0, resp_misaligned}, 32'h0);
      end
      prev_valid = resp_valid;
    end
  end

  task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input logic em, input int lat, input int we);
    exp_t e;
    int   waited;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    e.rdata   = er;
    e.mis     = em;
    e.lat     = lat;
    e.we      = we;
    e.acc_cyc = cyc;
    e.we_base = we_cnt;
    sb_q.push_back(e);
    name_q.push_back(name);
    req_valid = 1'b0;
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s timeout: got no response, expected one within 20 cycles", name);
      sb_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    int base;
    #1;
    check("rst req_ready", {31'b0, req_ready}, 32'h1);
    check("rst resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst resp_misaligned", {31'b0, resp_misaligned}, 32'h0);
    check("rst mem_address", {22'b0, mem_address}, 32'h0);
    check("rst mem_in", mem_in, 32'h0);
    check("rst mem_we", {31'b0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     name        w     size   u     addr          wdata         exp_rdata     mis  lat we
    issue("sw_10",     1'b1, 2'b10, 1'b0, 32'h10,       32'h8899AABB, 32'h0,        1'b0, 2, 1);
    issue("lw_10",     1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h8899AABB, 1'b0, 3, 0);
    issue("lb_10",     1'b0, 2'b00, 1'b0, 32'h10,       32'h0,        32'hFFFFFFBB, 1'b0, 3, 0);
    issue("lbu_11",    1'b0, 2'b00, 1'b1, 32'h11,       32'h0,        32'h000000AA, 1'b0, 3, 0);
    issue("lh_12",     1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        32'hFFFF8899, 1'b0, 3, 0);
    issue("lhu_12",    1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        32'h00008899, 1'b0, 3, 0);
    issue("sb_13",     1'b1, 2'b00, 1'b0, 32'h13,       32'hFFFFFF5A, 32'h0,        1'b0, 4, 1);
    issue("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h10,     32'h0,        32'h5A99AABB, 1'b0, 3, 0);
    issue("sh_10",     1'b1, 2'b01, 1'b0, 32'h10,       32'hABCD1234, 32'h0,        1'b0, 4, 1);
    issue("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h10,     32'h0,        32'h5A991234, 1'b0, 3, 0);
    issue("mis_lw_06", 1'b0, 2'b10, 1'b0, 32'h06,       32'h0,        32'h0,        1'b1, 1, 0);
    issue("mis_sh_11", 1'b1, 2'b01, 1'b0, 32'h11,       32'hFFFF,     32'h0,        1'b1, 1, 0);
    issue("mis_sz_11", 1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0);
    issue("sw_wrap",   1'b1, 2'b10, 1'b0, 32'h1000,     32'hDEADBEEF, 32'h0,        1'b0, 2, 1);
    issue("lw_wrap",   1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 3, 0);

    // Abort a byte store with reset while it sits in RD_DATA.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h10;
    req_wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    base = we_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort mem_we", {31'b0, mem_we}, 32'h0);
    check("abort resp_valid", {31'b0, resp_valid}, 32'h0);
    check("abort req_ready", {31'b0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort no_write", we_cnt - base, 0);
    issue("lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5A991234, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-only `datamemory` block. It turns byte-addressed load/store requests (byte, halfword, word; signed or unsigned) into word accesses on the memory's single-port, registered-read interface. Sub-word stores use a read-modify-write sequence because the memory has no byte enables. The unit reports alignment errors and produces a one-cycle response per request.

## Interface
- `DATA_WIDTH`, 32, data word width; the unit is fixed at 32.
- `ADDR_WIDTH`, 10, memory word-address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high exactly in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned`  in  1  zero-extend sub-word loads; ignored for word loads and all stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low byte/half used for sub-word stores.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_misaligned`  out  1  qualifies `resp_valid`; error, no memory access.
- `mem_address`  out  ADDR_WIDTH  word address, `req_addr[ADDR_WIDTH+1:2]`.
- `mem_in`  out  DATA_WIDTH  write word.
- `mem_we`  out  1  memory write enable.
- `mem_out`  in  DATA_WIDTH  memory read data, valid the cycle after a read cycle.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. Request fields are latched at acceptance. `req_valid` is ignored while busy, so the requester holds the request.
- Endianness is little: byte offset `a = req_addr[1:0]` selects bits `[8a+7:8a]`; the half at offset 2 is `[31:16]`.
- Misaligned: half with `addr[0]=1`, word with `addr[1:0]!=0`, or `req_size=11`. These go to RESP with `resp_misaligned=1` and no memory cycle.
- Address bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo `4<<ADDR_WIDTH`.
- FSM states: IDLE, RD, RD_DATA, WR, RESP. RESP is implicit: it is the IDLE cycle in which the registered `resp_valid` is high.
  - IDLE → WR: aligned word store. `mem_in=req_wdata`.
  - IDLE → RD: load, or aligned sub-word store.
  - IDLE → IDLE with an error response: misaligned request.
  - RD: drive `mem_address`, `mem_we=0`. Always → RD_DATA.
  - RD_DATA, load: extract and extend `mem_out`, register it into `resp_rdata`, → IDLE with `resp_valid`.
  - RD_DATA, sub-word store: merge the new byte/half into `mem_out`, register the result into `mem_in`, → WR.
  - WR: `mem_we=1` for exactly this cycle, → IDLE with `resp_valid`.
- `mem_*` outputs are registered. `mem_we` is 0 in every state other than WR.
- Reset mid-operation aborts the transaction: no write, no response.

## Timing
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_misaligned=0`, `mem_address=0`, `mem_in=0`, `mem_we=0`. Reset applies asynchronously, including forcing `mem_we` to 0 immediately.
- Latency is counted from accept edge T to the `resp_valid` cycle:
  - Error: 1 cycle.
  - Word store: 2 cycles (WR at T+1).
  - Load: 3 cycles (RD at T+1, RD_DATA at T+2).
  - Sub-word store: 4 cycles (WR at T+3).
- `req_ready` is high during the `resp_valid` cycle, so back-to-back acceptance is allowed.
- `resp_rdata` and `resp_misaligned` are valid only while `resp_valid` is high. They are cleared to 0 the following cycle.

## Structure
- Package `mips_mem_pkg` holds:
  - the size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the state enum `lsu_state_t`;
  - the pure functions `lsu_extract(word, offset, size, unsigned)` and `lsu_merge(word, wdata, offset, size)`.
- One combinational sub-module, `lsu_byte_lane`, wraps extract/merge. The FSM and registers live in `load_store_unit`.

## Test plan
- Word store 0x8899AABB at 0x10, then lw 0x10 → `resp_rdata=0x8899AABB`. Load latency is 3; `mem_we` is high exactly one cycle.
- Loads from the same word:
  - lb 0x10 → 0xFFFFFFBB
  - lbu 0x11 → 0x000000AA
  - lh 0x12 → 0xFFFF8899
  - lhu 0x12 → 0x00008899
- sb 0x5A at 0x13, then lw 0x10 → 0x5A99AABB. Then sh 0x1234 at 0x10, then lw → 0x5A991234. Sub-word store latency is 4.
- lw at 0x06, sh at 0x11, and `req_size=11` each → `resp_misaligned=1` at T+1, `resp_rdata=0`, `mem_we` never asserted.
- sw 0xDEADBEEF at 0x1000 (`ADDR_WIDTH=10`), then lw 0x0 → 0xDEADBEEF (wrap).
- Assert `rst_n=0` during RD_DATA of an sb → `mem_we` stays 0, no `resp_valid`, `req_ready=1`, and the target word is unchanged.
